// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK flop bank driver.
// Holds the command opcodes, controller states and INIT length.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_SET    = 2'd1,
    OP_CLR    = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    DRIVE = 3'd2,
    CHECK = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam int INIT_CYCLES = 1;

endpackage

// File: rtl/jk_excite_enc.sv
// Combinational map from a register-level operation to per-bit J/K excitation
// and the bank contents expected once that excitation has been applied.
module jk_excite_enc
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] shadow_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] shadow_nxt_o
);

  // J=1,K=0 sets, J=0,K=1 clears, J=K=1 toggles, J=K=0 holds.
  always_comb begin
    j_o          = '0;
    k_o          = '0;
    shadow_nxt_o = shadow_i;
    case (op_i)
      OP_LOAD: begin
        j_o          = data_i;
        k_o          = ~data_i;
        shadow_nxt_o = data_i;
      end
      OP_SET: begin
        j_o          = data_i;
        shadow_nxt_o = shadow_i | data_i;
      end
      OP_CLR: begin
        k_o          = data_i;
        shadow_nxt_o = shadow_i & ~data_i;
      end
      OP_TOGGLE: begin
        j_o          = data_i;
        k_o          = data_i;
        shadow_nxt_o = shadow_i ^ data_i;
      end
      default: begin
        shadow_nxt_o = shadow_i;
      end
    endcase
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Command-driven controller for a bank of JK flops sharing one enable.
// Define JK_DRV_CHECK_EN to compare q_fb against the shadow after each command.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             en,
  output logic [WIDTH-1:0] shadow_q,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int INIT_CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [INIT_CNT_W-1:0] initCnt_q, initCnt_d;
  logic [WIDTH-1:0]      j_q, j_d;
  logic [WIDTH-1:0]      k_q, k_d;
  logic                  en_q, en_d;
  logic                  cmdReady_q, cmdReady_d;
  logic [WIDTH-1:0]      shadowBits_q, shadowBits_d;
  logic                  done_q, done_d;

  logic [WIDTH-1:0]      encJ, encK, encShadow;

  jk_excite_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .op_i        (op_e'(cmd_op)),
    .data_i      (cmd_data),
    .shadow_i    (shadowBits_q),
    .j_o         (encJ),
    .k_o         (encK),
    .shadow_nxt_o(encShadow)
  );

`ifdef JK_DRV_CHECK_EN
  logic errBit_q, errBit_d;
  assign err = errBit_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{q_fb, err_clr};
  assign err = 1'b0;
`endif

  // Every output is registered, so each branch sets the values seen in the
  // destination state; en only ever drops for INIT, which clears the bank.
  always_comb begin
    state_d      = state_q;
    initCnt_d    = initCnt_q;
    j_d          = '0;
    k_d          = '0;
    en_d         = 1'b1;
    cmdReady_d   = 1'b0;
    shadowBits_d = shadowBits_q;
    done_d       = 1'b0;
`ifdef JK_DRV_CHECK_EN
    errBit_d     = errBit_q;
`endif
    case (state_q)
      INIT: begin
        shadowBits_d = '0;
        if (initCnt_q == INIT_LAST) begin
          state_d    = IDLE;
          initCnt_d  = '0;
          cmdReady_d = 1'b1;
        end else begin
          en_d      = 1'b0;
          initCnt_d = initCnt_q + 1'b1;
        end
      end
      IDLE: begin
        cmdReady_d = 1'b1;
        if (cmd_valid && cmdReady_q) begin
          state_d      = DRIVE;
          j_d          = encJ;
          k_d          = encK;
          shadowBits_d = encShadow;
          cmdReady_d   = 1'b0;
        end
      end
      DRIVE: begin
`ifdef JK_DRV_CHECK_EN
        state_d = CHECK;
`else
        state_d    = IDLE;
        cmdReady_d = 1'b1;
        done_d     = 1'b1;
`endif
      end
`ifdef JK_DRV_CHECK_EN
      CHECK: begin
        if (q_fb == shadowBits_q) begin
          state_d    = IDLE;
          cmdReady_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          state_d  = ERR;
          errBit_d = 1'b1;
        end
      end
      ERR: begin
        if (err_clr) begin
          state_d      = INIT;
          en_d         = 1'b0;
          errBit_d     = 1'b0;
          shadowBits_d = '0;
        end
      end
`endif
      default: begin
        state_d      = INIT;
        en_d         = 1'b0;
        shadowBits_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      initCnt_q    <= '0;
      j_q          <= '0;
      k_q          <= '0;
      en_q         <= 1'b0;
      cmdReady_q   <= 1'b0;
      shadowBits_q <= '0;
      done_q       <= 1'b0;
`ifdef JK_DRV_CHECK_EN
      errBit_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      initCnt_q    <= initCnt_d;
      j_q          <= j_d;
      k_q          <= k_d;
      en_q         <= en_d;
      cmdReady_q   <= cmdReady_d;
      shadowBits_q <= shadowBits_d;
      done_q       <= done_d;
`ifdef JK_DRV_CHECK_EN
      errBit_q     <= errBit_d;
`endif
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign en        = en_q;
  assign cmd_ready = cmdReady_q;
  assign shadow_q  = shadowBits_q;
  assign done      = done_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver driving a behavioural 8-bit JK bank.
// Expected results are queued at accept and compared when done pulses.
module tb_jk_bank_driver;

  localparam int WIDTH = 8;
`ifdef JK_DRV_CHECK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j, k, shadow_q;
  logic             en, done, err;
  logic             err_clr = 1'b0;

  logic [WIDTH-1:0] bank = 8'h3C;
  logic [WIDTH-1:0] forceMask = '0;
  int               cyc = 0;

  typedef struct {
    logic [WIDTH-1:0] shadow;
    int               doneCyc;
  } exp_t;
  exp_t sbQ[$];
  exp_t popped;

  int               checkCount = 0;
  int               passCount = 0;
  logic [WIDTH-1:0] modelShadow = '0;
  int               a0, a1, a2, a3;

  jk_bank_driver #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .en       (en),
    .shadow_q (shadow_q),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural ff_jk bank: cleared whenever en is low at an edge.
  always @(posedge clk) begin
    if (!en) bank <= '0;
    else     bank <= (j & ~bank) | (~k & bank);
  end
  assign q_fb = bank | forceMask;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void excite(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                 input logic [WIDTH-1:0] s, output logic [WIDTH-1:0] ej,
                                 output logic [WIDTH-1:0] ek, output logic [WIDTH-1:0] ns);
    case (op)
      2'd0:    begin ej = d;  ek = ~d; ns = d;      end
      2'd1:    begin ej = d;  ek = '0; ns = s | d;  end
      2'd2:    begin ej = '0; ek = d;  ns = s & ~d; end
      default: begin ej = d;  ek = d;  ns = s ^ d;  end
    endcase
  endfunction

  // Scoreboard pop side: every done must match the oldest queued command.
  always @(negedge clk) begin
    if (done) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        popped = sbQ.pop_front();
        checkOutput("done_cycle", cyc, popped.doneCyc);
        checkOutput("done_shadow", shadow_q, popped.shadow);
        checkOutput("done_qfb", q_fb, popped.shadow);
        checkOutput("done_err", err, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge inside the DRIVE cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] data,
                               input bit last, input bit track, output int acceptCyc);
    logic [WIDTH-1:0] ej, ek, ns;
    int waitCnt;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    waitCnt   = 0;
    while (!cmd_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    acceptCyc = cyc;
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    excite(op, data, modelShadow, ej, ek, ns);
    if (track) begin
      e.shadow  = ns;
      e.doneCyc = cyc + 1 + LAT;
      sbQ.push_back(e);
    end
    modelShadow = ns;
    @(negedge clk);
    checkOutput("drive_j", j, ej);
    checkOutput("drive_k", k, ek);
    checkOutput("drive_ready", cmd_ready, 32'd0);
    checkOutput("drive_en", en, 32'd1);
    checkOutput("drive_shadow", shadow_q, ns);
    if (last) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sbQ.size() != 0 || !cmd_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0 || !cmd_ready) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_en", en, 32'd0);
    checkOutput("rst_jk", {j, k}, 32'd0);
    checkOutput("rst_ready", cmd_ready, 32'd0);
    checkOutput("rst_shadow", shadow_q, 32'd0);
    checkOutput("rst_done_err", {done, err}, 32'd0);

    rst_n = 1'b1;
    checkOutput("init_en", en, 32'd0);
    @(negedge clk);
    checkOutput("idle_en", en, 32'd1);
    checkOutput("idle_ready", cmd_ready, 32'd1);
    checkOutput("init_clears_bank", q_fb, 32'd0);

    applyStimulus(2'd0, 8'hA5, 1'b1, 1'b1, a0);
    checkOutput("load_j", j, 32'hA5);
    checkOutput("load_k", k, 32'h5A);
    waitIdle();
    checkOutput("load_shadow", shadow_q, 32'hA5);
    checkOutput("load_qfb", q_fb, 32'hA5);

    applyStimulus(2'd1, 8'h0F, 1'b1, 1'b1, a0);
    waitIdle();
    checkOutput("set_shadow", shadow_q, 32'hAF);
    applyStimulus(2'd2, 8'h81, 1'b1, 1'b1, a0);
    waitIdle();
    checkOutput("clr_shadow", shadow_q, 32'h2E);
    applyStimulus(2'd3, 8'hFF, 1'b1, 1'b1, a0);
    waitIdle();
    checkOutput("tog_shadow", shadow_q, 32'hD1);
    checkOutput("tog_qfb", q_fb, 32'hD1);
    checkOutput("seq_err", err, 32'd0);

    // Back-to-back with cmd_valid never dropped; zero masks are no-ops.
    applyStimulus(2'd0, 8'h3C, 1'b0, 1'b1, a0);
    applyStimulus(2'd3, 8'h0F, 1'b0, 1'b1, a1);
    applyStimulus(2'd1, 8'h00, 1'b0, 1'b1, a2);
    applyStimulus(2'd2, 8'h00, 1'b1, 1'b1, a3);
    checkOutput("burst_gap1", a1 - a0, LAT + 1);
    checkOutput("burst_gap2", a2 - a1, LAT + 1);
    checkOutput("burst_gap3", a3 - a2, LAT + 1);
    waitIdle();
    checkOutput("burst_shadow", shadow_q, 32'h33);
    checkOutput("burst_qfb", q_fb, 32'h33);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("errclr_idle_ready", cmd_ready, 32'd1);
    checkOutput("errclr_idle_en", en, 32'd1);
    checkOutput("errclr_idle_shadow", shadow_q, 32'h33);
    checkOutput("errclr_idle_err", err, 32'd0);

`ifdef JK_DRV_CHECK_EN
    applyStimulus(2'd0, 8'h00, 1'b1, 1'b0, a0);
    forceMask = 8'h01;
    repeat (3) @(negedge clk);
    checkOutput("err_set", err, 32'd1);
    checkOutput("err_ready", cmd_ready, 32'd0);
    checkOutput("err_en", en, 32'd1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("err_no_accept", cmd_ready, 32'd0);
    checkOutput("err_sticky", err, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr   = 1'b0;
    forceMask = '0;
    checkOutput("reinit_err", err, 32'd0);
    checkOutput("reinit_en", en, 32'd0);
    checkOutput("reinit_shadow", shadow_q, 32'd0);
    checkOutput("reinit_ready", cmd_ready, 32'd0);
    @(negedge clk);
    modelShadow = '0;
    checkOutput("reidle_en", en, 32'd1);
    checkOutput("reidle_ready", cmd_ready, 32'd1);
    checkOutput("reidle_qfb", q_fb, 32'd0);
`endif

    applyStimulus(2'd3, 8'hFF, 1'b1, 1'b0, a0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_en", en, 32'd0);
    checkOutput("abort_jk", {j, k}, 32'd0);
    checkOutput("abort_shadow", shadow_q, 32'd0);
    checkOutput("abort_ready_done", {cmd_ready, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelShadow = '0;
    @(negedge clk);
    checkOutput("abort_idle_en", en, 32'd1);
    checkOutput("abort_idle_ready", cmd_ready, 32'd1);
    checkOutput("abort_bank_cleared", q_fb, 32'd0);

    applyStimulus(2'd1, 8'h81, 1'b1, 1'b1, a0);
    waitIdle();
    checkOutput("final_shadow", shadow_q, 32'h81);
    checkOutput("final_qfb", q_fb, 32'h81);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
